// File: rtl/jp_inv_lift_seq_if.sv
// Bus bundle for the inverse 5/3 lifting sequencer: control handshake plus the
// left/right/flags/residual read ports and the sample RAM write port.
interface jp_inv_lift_seq_if #(
  parameter int LANES = 16,
  parameter int SW    = 9,
  parameter int RW    = 10,
  parameter int FW    = 5,
  parameter int AW    = 10
);
  // Handshake: start is accepted only on a cycle where busy is low; busy then
  // stays high through the done cycle, and done pulses exactly once per
  // accepted start, one cycle after the single we_sa write-back pulse.
  logic                  start;
  logic [AW-1:0]         row_addr;
  logic                  busy;
  logic                  done;
  logic [AW-1:0]         addr_lf;
  logic [LANES*SW-1:0]   dout_lf;
  logic [AW-1:0]         addr_rt;
  logic [LANES*SW-1:0]   dout_rt;
  logic [AW-1:0]         addr_flgs;
  logic [LANES*FW-1:0]   dout_flgs;
  logic [AW-1:0]         addr_res;
  logic [RW-1:0]         dout_res;
  logic [AW-1:0]         addr_sa;
  logic [LANES*SW-1:0]   din_sa;
  logic                  we_sa;
  logic [2:0]            dbg_state;

  modport master (
    input  start, row_addr, dout_lf, dout_rt, dout_flgs, dout_res,
    output busy, done, addr_lf, addr_rt, addr_flgs, addr_res,
           addr_sa, din_sa, we_sa, dbg_state
  );

  modport slave (
    output start, row_addr, dout_lf, dout_rt, dout_flgs, dout_res,
    input  busy, done, addr_lf, addr_rt, addr_flgs, addr_res,
           addr_sa, din_sa, we_sa, dbg_state
  );
endinterface

// File: rtl/jp_inv_lift_seq.sv
// Inverse 5/3 lifting sequencer: one start reconstructs one packed row of LANES samples.
// Optional macro JP_INV_SAT_EN clamps each sample to [0, 2^SW-1]; otherwise samples wrap.
module jp_inv_lift_seq #(
  parameter int LANES  = 16,
  parameter int SW     = 9,
  parameter int RW     = 10,
  parameter int FW     = 5,
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic                clk_fast,
  input  logic                rst,
  jp_inv_lift_seq_if.master   bus
);
  localparam int XW = SW + 3;
  localparam int CW = $clog2(LANES + RD_LAT + 1);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RDROW = 3'd1,
    S_LANE  = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [AW-1:0]         r_row;
  logic [AW-1:0]         r_addr_res;
  logic [LANES*SW-1:0]   r_lf;
  logic [LANES*SW-1:0]   r_rt;
  logic [LANES*FW-1:0]   r_flgs;
  logic [LANES*SW-1:0]   r_word;

  logic                  w_rd_last;
  logic                  w_lane_last;
  logic [LW-1:0]         w_lane;
  logic [SW-1:0]         w_l;
  logic [SW-1:0]         w_r;
  logic [FW-1:0]         w_f;
  logic signed [XW-1:0]  w_sum;
  logic signed [XW-1:0]  w_e;
  logic signed [XW-1:0]  w_x;
  logic [SW-1:0]         w_x_pk;

  assign w_rd_last   = (r_cnt == CW'(RD_LAT - 1));
  assign w_lane_last = (r_cnt == CW'(LANES + RD_LAT - 1));
  // Residual for lane k lands RD_LAT cycles after its address, so the lane being
  // computed trails the LANE-cycle counter by RD_LAT.
  assign w_lane      = LW'(r_cnt - CW'(RD_LAT));

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RDROW;
      S_RDROW: if (w_rd_last) w_next = S_LANE;
      S_LANE:  if (w_lane_last) w_next = S_WR;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (r_state != S_IDLE);
    bus.done      = (r_state == S_DONE);
    bus.we_sa     = (r_state == S_WR);
    bus.addr_sa   = (r_state == S_WR) ? r_row  : '0;
    bus.din_sa    = (r_state == S_WR) ? r_word : '0;
    // Row words are requested in the accepting cycle so they arrive by the end of RDROW.
    if (r_state == S_IDLE) begin
      bus.addr_lf   = bus.start ? bus.row_addr : '0;
      bus.addr_rt   = bus.start ? bus.row_addr : '0;
      bus.addr_flgs = bus.start ? bus.row_addr : '0;
    end else begin
      bus.addr_lf   = r_row;
      bus.addr_rt   = r_row;
      bus.addr_flgs = r_row;
    end
    bus.addr_res  = r_addr_res;
    bus.dbg_state = r_state;
  end

  always_comb begin
    w_l    = r_lf[w_lane*SW +: SW];
    w_r    = r_rt[w_lane*SW +: SW];
    w_f    = r_flgs[w_lane*FW +: FW];
    w_sum  = $signed({3'b000, w_l}) + $signed({3'b000, w_r});
    w_e    = {{(XW-RW){bus.dout_res[RW-1]}}, bus.dout_res};
    if (w_f[1])      w_x = w_e;
    else if (w_f[0]) w_x = w_e + (w_sum >>> 1);
    else             w_x = w_e - ((w_sum + $signed(XW'(2))) >>> 2);
`ifdef JP_INV_SAT_EN
    if (w_x[XW-1])               w_x_pk = '0;
    else if (w_x[XW-2:SW] != '0) w_x_pk = '1;
    else                         w_x_pk = w_x[SW-1:0];
`else
    w_x_pk = w_x[SW-1:0];
`endif
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_row      <= '0;
      r_addr_res <= '0;
      r_lf       <= '0;
      r_rt       <= '0;
      r_flgs     <= '0;
      r_word     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.start) r_row <= bus.row_addr;
        end
        S_RDROW: begin
          if (w_rd_last) begin
            r_cnt      <= '0;
            r_lf       <= bus.dout_lf;
            r_rt       <= bus.dout_rt;
            r_flgs     <= bus.dout_flgs;
            r_addr_res <= r_row * AW'(LANES);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LANE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt < CW'(LANES - 1)) r_addr_res <= r_addr_res + 1'b1;
          if (r_cnt >= CW'(RD_LAT))   r_word[w_lane*SW +: SW] <= w_x_pk;
        end
        default: r_cnt <= '0;
      endcase
    end
  end
endmodule
